// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier.
// Holds the FSM state encoding and the result latency formula.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mult_state_t;

   localparam int unsigned ZERO_LATENCY = 2;

   // Edges from the start-sampling edge to the edge that sees done high.
   function automatic int unsigned mult_latency(input int unsigned width,
                                                input int unsigned bits_per_cycle);
      return width / bits_per_cycle + 2;
   endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^BITS_PER_CYCLE accumulate step: acc + (|A| * B slice) << shift.
module mult_step #(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1,
   parameter int unsigned SHIFT_W        = 6
) (
   input  logic [2*WIDTH-1:0]        acc,
   input  logic [WIDTH-1:0]          a_mag,
   input  logic [BITS_PER_CYCLE-1:0] b_slice,
   input  logic [SHIFT_W-1:0]        shift,
   output logic [2*WIDTH-1:0]        acc_next
);

   logic [2*WIDTH-1:0] partial;

   // Product of W and BITS_PER_CYCLE bits always fits in 2*WIDTH, so no truncation.
   always_comb begin
      partial  = {{WIDTH{1'b0}}, a_mag} * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, b_slice};
      acc_next = acc + (partial << shift);
   end

endmodule

// File: rtl/seq_multiplier_unit.sv
// Multi-cycle signed/unsigned multiplier with start/busy/done handshake.
// Works on magnitudes, then applies the sign in a separate FIX cycle.
module seq_multiplier_unit
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clock_signal,
   input  logic             reset_signal,
   input  logic             start_signal,
   input  logic             signed_multiplication,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy_signal,
   output logic             done_signal,
   output logic [WIDTH-1:0] high_output,
   output logic [WIDTH-1:0] low_output
);

   localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = $clog2(STEPS + 1);
   localparam int unsigned SH_W  = $clog2(2 * WIDTH);

   if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bits_per_cycle
      $error("BITS_PER_CYCLE must divide WIDTH");
   end

   mult_state_t        state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [SH_W-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0]   a_mag_q, a_mag_d;
   logic [WIDTH-1:0]   b_mag_q, b_mag_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   high_q, high_d;
   logic [WIDTH-1:0]   low_q, low_d;

   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] fixed;
   logic               accept;

   mult_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE),
      .SHIFT_W        (SH_W)
   ) u_step (
      .acc      (acc_q),
      .a_mag    (a_mag_q),
      .b_slice  (b_mag_q[BITS_PER_CYCLE-1:0]),
      .shift    (shift_q),
      .acc_next (acc_step)
   );

   // DONE also accepts so a new operation can start on the edge that leaves it.
   assign accept = start_signal && (state_q == IDLE || state_q == DONE);
   assign fixed  = neg_q ? -acc_q : acc_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      shift_d = shift_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      high_d  = high_q;
      low_d   = low_q;

      case (state_q)
         CALC: begin
            acc_d   = acc_step;
            b_mag_d = b_mag_q >> BITS_PER_CYCLE;
            count_d = count_q - CNT_W'(1);
            shift_d = shift_q + SH_W'(BITS_PER_CYCLE);
            if (count_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            high_d  = fixed[2*WIDTH-1:WIDTH];
            low_d   = fixed[WIDTH-1:0];
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         a_mag_d = (signed_multiplication && multiplicand[WIDTH-1]) ? -multiplicand
                                                                    : multiplicand;
         b_mag_d = (signed_multiplication && multiplier[WIDTH-1]) ? -multiplier : multiplier;
         neg_d   = signed_multiplication && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
         acc_d   = '0;
         count_d = CNT_W'(STEPS);
         shift_d = '0;
         state_d = (multiplicand == '0 || multiplier == '0) ? FIX : CALC;
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock_signal) begin
      if (reset_signal) begin
         state_q <= IDLE;
         count_q <= '0;
         shift_q <= '0;
         a_mag_q <= '0;
         b_mag_q <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         high_q  <= '0;
         low_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         shift_q <= shift_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         high_q  <= high_d;
         low_q   <= low_d;
      end
   end

   assign busy_signal = busy_q;
   assign done_signal = done_q;
   assign high_output = high_q;
   assign low_output  = low_q;

endmodule

// File: tb/tb_seq_multiplier_unit.sv
// Directed bench for seq_multiplier_unit: one instance at defaults, one with BITS_PER_CYCLE=4.
// Latency n means done is first seen high in the cycle before the n-th edge after the start edge.
module tb_seq_multiplier_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0;
   logic        start4 = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] mcand = '0;
   logic [31:0] mplier = '0;
   logic        sel = 1'b0;

   logic        busy1, done1, busy4, done4;
   logic [31:0] hi1, lo1, hi4, lo4;
   logic        busy_m, done_m;
   logic [31:0] hi_m, lo_m;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   seq_multiplier_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
      .clock_signal          (clk),
      .reset_signal          (rst),
      .start_signal          (start1),
      .signed_multiplication (sgn),
      .multiplicand          (mcand),
      .multiplier            (mplier),
      .busy_signal           (busy1),
      .done_signal           (done1),
      .high_output           (hi1),
      .low_output            (lo1)
   );

   seq_multiplier_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
      .clock_signal          (clk),
      .reset_signal          (rst),
      .start_signal          (start4),
      .signed_multiplication (sgn),
      .multiplicand          (mcand),
      .multiplier            (mplier),
      .busy_signal           (busy4),
      .done_signal           (done4),
      .high_output           (hi4),
      .low_output            (lo4)
   );

   assign busy_m = sel ? busy4 : busy1;
   assign done_m = sel ? done4 : done1;
   assign hi_m   = sel ? hi4 : hi1;
   assign lo_m   = sel ? lo4 : lo1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic launch(input logic s4, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk);
      sel    = s4;
      sgn    = s;
      mcand  = a;
      mplier = b;
      start1 = !s4;
      start4 = s4;
   endtask

   // Waits for done; at negedge number 'poke' re-asserts start with operands pa/pb.
   task automatic wait_done(input int poke, input logic [31:0] pa, input logic [31:0] pb,
                            output int n, output int busy_n);
      n      = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy_m) busy_n++;
         if (n == poke) begin
            mcand  = pa;
            mplier = pb;
         end
         start1 = !sel && (n == poke);
         start4 = sel && (n == poke);
      end while (!done_m && n < 200);
   endtask

   task automatic do_op(input string tag, input logic s4, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
      int n, busy_n;
      launch(s4, s, a, b);
      wait_done(0, '0, '0, n, busy_n);
      check_val({tag, " latency"}, 32'(n), 32'(elat));
      check_val({tag, " high"}, hi_m, ehi);
      check_val({tag, " low"}, lo_m, elo);
      check_val({tag, " busy cycles"}, 32'(busy_n), 32'(elat));
   endtask

   task automatic post_check(input string tag);
      @(negedge clk);
      check_val({tag, " done pulse ends"}, 32'(done_m), 32'd0);
      check_val({tag, " busy drops"}, 32'(busy_m), 32'd0);
   endtask

   initial begin
      int n, busy_n, done_seen;

      repeat (3) @(negedge clk);
      check_val("reset busy", 32'(busy1), 32'd0);
      check_val("reset done", 32'(done1), 32'd0);
      check_val("reset high", hi1, 32'd0);
      check_val("reset low", lo1, 32'd0);
      rst = 1'b0;

      do_op("unsigned max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
            32'h0000_0001, 34);
      post_check("unsigned max");
      do_op("signed -3*5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
      do_op("signed -1*-1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 34);
      do_op("signed min*min", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,
            32'h0, 34);
      do_op("zero signed", 1'b0, 1'b1, 32'h0, 32'h1234, 32'h0, 32'h0, 2);
      post_check("zero signed");
      do_op("unsigned min*min", 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000,
            32'h0, 34);
      do_op("zero unsigned", 1'b0, 1'b0, 32'h0, 32'h1234, 32'h0, 32'h0, 2);
      post_check("zero unsigned");

      // Start during CALC with new operands must be dropped.
      launch(1'b0, 1'b0, 32'd6, 32'd7);
      wait_done(5, 32'd100, 32'd100, n, busy_n);
      check_val("ignored start latency", 32'(n), 32'd34);
      check_val("ignored start low", lo1, 32'd42);
      post_check("ignored start");
      check_val("ignored start held", lo1, 32'd42);

      // Back-to-back: start raised in the DONE cycle.
      launch(1'b0, 1'b0, 32'd3, 32'd4);
      wait_done(0, '0, '0, n, busy_n);
      check_val("b2b first low", lo1, 32'd12);
      mcand  = 32'd5;
      mplier = 32'd6;
      start1 = 1'b1;
      wait_done(0, '0, '0, n, busy_n);
      check_val("b2b second latency", 32'(n), 32'd34);
      check_val("b2b second low", lo1, 32'd30);
      check_val("b2b busy held", 32'(busy_n), 32'd34);

      // Reset in the middle of CALC.
      launch(1'b0, 1'b0, 32'd9, 32'd9);
      @(negedge clk);
      start1 = 1'b0;
      repeat (9) @(negedge clk);
      check_val("pre-reset busy", 32'(busy1), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("abort busy", 32'(busy1), 32'd0);
      check_val("abort high", hi1, 32'd0);
      check_val("abort low", lo1, 32'd0);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done1) done_seen++;
      end
      check_val("abort no done", 32'(done_seen), 32'd0);

      do_op("bpc4 7*-9", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 10);
      post_check("bpc4 7*-9");
      do_op("bpc4 unsigned max", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
            32'h0000_0001, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
